seq_checker: RTL and testbench



---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_code_lut.sv | 23 ++
 rtl/seq_checker.sv | 107 ++++++++++
 tb/tb_seq_checker.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: code table, state encoding and pointer helper shared by the generator and the checker.
package seq_pkg;
  localparam int SEQ_LEN = 9;
  localparam logic [SEQ_LEN-1:0][7:0] SEQ_TABLE = {
    8'd0, 8'd155, 8'd1, 8'd24, 8'd233, 8'd59, 8'd34, 8'd12, 8'd3
  };
  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] CONFIRM = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;
  function automatic logic [3:0] next_idx(input logic [3:0] i);
    return (i == 4'(SEQ_LEN - 1)) ? 4'd0 : i + 4'd1;
  endfunction
endpackage

// File: rtl/seq_code_lut.sv
// seq_code_lut: combinational forward (idx -> code) and reverse (code -> hit, idx) table lookup.
module seq_code_lut
  import seq_pkg::*;
(
  input  logic [3:0] idx_i,
  output logic [7:0] code_o,
  input  logic [7:0] code_i,
  output logic       hit_o,
  output logic [3:0] hit_idx_o
);
  assign code_o = (idx_i < 4'(SEQ_LEN)) ? SEQ_TABLE[idx_i] : 8'd0;
  // Codes are unique, so at most one entry can match.
  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = 4'd0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (code_i == SEQ_TABLE[k]) begin
        hit_o     = 1'b1;
        hit_idx_o = 4'(k);
      end
    end
  end
endmodule

// File: rtl/seq_checker.sv
// seq_checker: hunts, confirms and tracks lock on the cyclic code sequence, counting mismatches.
// Define SEQ_CHECK_RESYNC_EN to let a misplaced table code re-align the pointer while locked.
module seq_checker
  import seq_pkg::*;
#(
  parameter int unsigned LOCK_CNT  = 3,
  parameter int unsigned LOSS_CNT  = 2,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din_valid,
  input  logic [7:0]           din,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [7:0]           exp_data,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           state
);
  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);
  logic [1:0]           state_q, state_d;
  logic [3:0]           idx_q, idx_d, good_q, good_d, miss_q, miss_d, hit_idx;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]           exp_q, exp_d, code;
  logic                 err_pulse_q, err_pulse_d, locked_q, hit, match;
  seq_code_lut u_lut (
    .idx_i     (idx_d),
    .code_o    (code),
    .code_i    (din),
    .hit_o     (hit),
    .hit_idx_o (hit_idx)
  );
  // exp_q always holds table[idx_q] outside HUNT, so it doubles as the compare value.
  assign match = (din == exp_q);
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    good_d      = good_q;
    miss_d      = miss_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (hit) begin
          idx_d   = next_idx(hit_idx);
          good_d  = 4'd0;
          state_d = CONFIRM;
        end
      end else if (state_q == CONFIRM) begin
        if (match) begin
          idx_d  = next_idx(idx_q);
          good_d = good_q + 4'd1;
          if (good_d == LOCK_C) begin
            state_d = LOCKED;
            miss_d  = 4'd0;
          end
        end else begin
          state_d = HUNT;
        end
      end else if (state_q == LOCKED) begin
        idx_d = next_idx(idx_q);
        if (match) begin
          miss_d = 4'd0;
        end else begin
          err_pulse_d = 1'b1;
          err_cnt_d   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
          miss_d      = miss_q + 4'd1;
`ifdef SEQ_CHECK_RESYNC_EN
          if (hit) begin
            idx_d  = next_idx(hit_idx);
            miss_d = 4'd0;
          end
`endif
          if (miss_d == LOSS_C) state_d = HUNT;
        end
      end
    end
  end
  assign exp_d = (state_d == HUNT) ? 8'd0 : code;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      idx_q       <= 4'd0;
      good_q      <= 4'd0;
      miss_q      <= 4'd0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
      exp_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= (state_d == LOCKED);
      exp_q       <= exp_d;
    end
  end
  assign state     = state_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign exp_data  = exp_q;
  assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: directed plus random stimulus checked against a table-driven reference model.
module tb_seq_checker;
  localparam int LOCK_CNT = 3;
  localparam int LOSS_CNT = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic [7:0]  din = 8'd0;
  logic        locked, err_pulse;
  logic [7:0]  exp_data;
  logic [15:0] err_cnt;
  logic [1:0]  state;
  int checks = 0;
  int errors = 0;
  int tbl[9] = '{3, 12, 34, 59, 233, 24, 1, 155, 0};
  int m_st, m_idx, m_good, m_miss, m_err, m_pulse;

  seq_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_CNT_W(16)) dut (
    .clk       (clk),
    .reset     (rst),
    .din_valid (din_valid),
    .din       (din),
    .locked    (locked),
    .err_pulse (err_pulse),
    .exp_data  (exp_data),
    .err_cnt   (err_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  function automatic int find(input int b);
    for (int k = 0; k < 9; k++) if (tbl[k] == b) return k;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_good = 0; m_miss = 0; m_err = 0; m_pulse = 0;
  endtask

  // Reference: 0=hunting, 1=confirming, 2=locked; pointer wraps with modulo 9.
  task automatic model_step(input bit v, input int b);
    int k;
    m_pulse = 0;
    if (!v) return;
    k = find(b);
    if (m_st == 0) begin
      if (k >= 0) begin m_idx = (k + 1) % 9; m_good = 0; m_st = 1; end
    end else if (m_st == 1) begin
      if (b == tbl[m_idx]) begin
        m_idx = (m_idx + 1) % 9;
        m_good++;
        if (m_good == LOCK_CNT) begin m_st = 2; m_miss = 0; end
      end else m_st = 0;
    end else begin
      if (b == tbl[m_idx]) begin
        m_idx = (m_idx + 1) % 9; m_miss = 0;
      end else begin
        m_pulse = 1;
        if (m_err < 65535) m_err++;
        m_miss++;
        m_idx = (m_idx + 1) % 9;
`ifdef SEQ_CHECK_RESYNC_EN
        if (k >= 0) begin m_idx = (k + 1) % 9; m_miss = 0; end
`endif
        if (m_miss == LOSS_CNT) m_st = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_st));
    chk({tag, ".locked"}, 32'(locked), 32'(m_st == 2));
    chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
    chk({tag, ".exp_data"}, 32'(exp_data), (m_st == 0) ? 32'd0 : 32'(tbl[m_idx]));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
  endtask

  task automatic send(input bit v, input int b, input string tag);
    din_valid = v;
    din = 8'(b);
    @(posedge clk);
    model_step(v, b);
    #1;
    check_all(tag);
  endtask

  initial begin
    int r, b;
    model_reset();
    #2;
    check_all("reset_init");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(1, 3, "clean");
    chk("confirm_after_3", 32'(state), 32'd1);
    send(1, 12, "clean");
    send(1, 34, "clean");
    send(1, 59, "clean");
    chk("locked_after_59", 32'(locked), 32'd1);
    chk("exp_233_at_lock", 32'(exp_data), 32'd233);
    for (int i = 0; i < 27; i++) send(1, tbl[(i + 4) % 9], "wrap");
    chk("no_err_after_wraps", 32'(err_cnt), 32'd0);
    send(1, 77, "bad1");
    chk("bad1_pulse", 32'(err_pulse), 32'd1);
    chk("bad1_exp24", 32'(exp_data), 32'd24);
    chk("bad1_cnt", 32'(err_cnt), 32'd1);
    send(1, 77, "bad2");
    chk("bad2_unlocked", 32'(locked), 32'd0);
    chk("bad2_cnt", 32'(err_cnt), 32'd2);
    foreach (tbl[i]) if (i < 3) send(1, 5 + i, "garbage");
    chk("garbage_hunt", 32'(state), 32'd0);
    send(1, 59, "acq59");
    chk("acq59_exp", 32'(exp_data), 32'd233);
    send(1, 1, "confirm_bad");
    chk("confirm_bad_hunt", 32'(state), 32'd0);
    chk("confirm_bad_cnt", 32'(err_cnt), 32'd2);
    send(1, 3, "relock"); send(1, 12, "relock"); send(1, 34, "relock"); send(1, 59, "relock");
    for (int i = 4; i < 8; i++) begin
      send(1, tbl[i], "gap_byte");
      repeat (4) send(0, 99, "gap_idle");
    end
    chk("gap_locked", 32'(locked), 32'd1);
    chk("gap_exp", 32'(exp_data), 32'd0);
    for (int i = 0; i < 3; i++) begin
      send(1, 77, "err_fill");
      send(1, tbl[m_idx], "err_fill_ok");
    end
    chk("err_cnt_5", 32'(err_cnt), 32'd5);
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst = 1'b0;
`ifdef SEQ_CHECK_RESYNC_EN
    for (int i = 0; i < 11; i++) send(1, tbl[i % 9], "rs_lock");
    chk("rs_exp34", 32'(exp_data), 32'd34);
    send(1, 59, "rs_skip");
    chk("rs_pulse", 32'(err_pulse), 32'd1);
    chk("rs_locked", 32'(locked), 32'd1);
    send(1, 233, "rs_233");
    chk("rs_233_nopulse", 32'(err_pulse), 32'd0);
`endif
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7 && m_st != 0) b = tbl[m_idx];
      else if (r < 9) b = tbl[$urandom_range(0, 8)];
      else b = $urandom_range(0, 255);
      send(($urandom_range(0, 3) != 0), b, "rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
